// File: rtl/al_clk_set_ctrl.sv
// al_clk_set_ctrl: keypad time-entry controller for the alarm clock.
// Collects up to four BCD digits, validates them as HH:MM on a set key and
// issues a one-cycle load strobe to the clock counter or the alarm register.
//
// Ports:
//   i_clk           system clock
//   i_reset         synchronous, active-high reset
//   i_key_valid     single-cycle strobe qualifying i_key_code
//   i_key_code      0-9 digit, A set-time, B set-alarm, C cancel, D-F ignored
//   i_one_second    single-cycle tick, once per second
//   i_current_time  running BCD HH:MM from the clock counter
//   o_time_out      committed BCD value (counter time_in / alarm data)
//   o_load_new_time one-cycle load strobe to the clock counter
//   o_load_alarm    one-cycle load strobe to the alarm register
//   o_display_time  value to display: keys being entered, else running time
//   o_show_keys     high while an entry is in progress
//   o_entry_error   one-cycle strobe on a rejected commit
module al_clk_set_ctrl #(
    parameter int unsigned TIMEOUT_TICKS = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_key_valid,
    input  logic [3:0]  i_key_code,
    input  logic        i_one_second,
    input  logic [15:0] i_current_time,
    output logic [15:0] o_time_out,
    output logic        o_load_new_time,
    output logic        o_load_alarm,
    output logic [15:0] o_display_time,
    output logic        o_show_keys,
    output logic        o_entry_error
);

    typedef enum logic [1:0] {StIdle, StEntry, StLoadTime, StLoadAlarm} state_e;

    // Tick count at which the next tick expires the entry.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_TICKS - 1);

    state_e      r_state, w_state_d;
    logic [15:0] r_key_buffer, w_key_buffer_d;
    logic [2:0]  r_digit_cnt, w_digit_cnt_d;
    logic [7:0]  r_timeout_cnt, w_timeout_cnt_d;
    logic [15:0] r_time_out, w_time_out_d;
    logic        r_load_new_time, r_load_alarm, r_entry_error, r_show_keys;
    logic        w_entry_error_d;

    logic w_is_digit, w_is_set_time, w_is_set_alarm, w_is_cancel, w_valid;
    logic [3:0] w_h1, w_h0, w_m1, w_m0;

    assign w_is_digit     = (i_key_code <= 4'd9);
    assign w_is_set_time  = (i_key_code == 4'hA);
    assign w_is_set_alarm = (i_key_code == 4'hB);
    assign w_is_cancel    = (i_key_code == 4'hC);

    assign w_h1 = r_key_buffer[15:12];
    assign w_h0 = r_key_buffer[11:8];
    assign w_m1 = r_key_buffer[7:4];
    assign w_m0 = r_key_buffer[3:0];

    assign w_valid = (r_digit_cnt == 3'd4) && (w_h1 <= 4'd2) && (w_h0 <= 4'd9) &&
                     !((w_h1 == 4'd2) && (w_h0 > 4'd3)) &&
                     (w_m1 <= 4'd5) && (w_m0 <= 4'd9);

    always_comb begin
        w_state_d       = r_state;
        w_key_buffer_d  = r_key_buffer;
        w_digit_cnt_d   = r_digit_cnt;
        w_timeout_cnt_d = r_timeout_cnt;
        w_time_out_d    = r_time_out;
        w_entry_error_d = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_key_valid && w_is_digit) begin
                    w_state_d       = StEntry;
                    w_key_buffer_d  = {12'h000, i_key_code};
                    w_digit_cnt_d   = 3'd1;
                    w_timeout_cnt_d = 8'd0;
                end
            end
            StEntry: begin
                // A key press takes priority over a coincident one_second tick.
                if (i_key_valid) begin
                    w_timeout_cnt_d = 8'd0;
                    if (w_is_digit) begin
                        w_key_buffer_d = {r_key_buffer[11:0], i_key_code};
                        if (r_digit_cnt != 3'd4) begin
                            w_digit_cnt_d = r_digit_cnt + 3'd1;
                        end
                    end else if (w_is_cancel) begin
                        w_state_d      = StIdle;
                        w_key_buffer_d = 16'h0000;
                        w_digit_cnt_d  = 3'd0;
                    end else if (w_is_set_time || w_is_set_alarm) begin
                        if (w_valid) begin
                            w_time_out_d = r_key_buffer;
                            w_state_d    = w_is_set_time ? StLoadTime : StLoadAlarm;
                        end else begin
                            w_entry_error_d = 1'b1;
                            w_state_d       = StIdle;
                            w_key_buffer_d  = 16'h0000;
                            w_digit_cnt_d   = 3'd0;
                        end
                    end
                end else if (i_one_second) begin
                    if (r_timeout_cnt == TimeoutLast) begin
                        w_state_d       = StIdle;
                        w_key_buffer_d  = 16'h0000;
                        w_digit_cnt_d   = 3'd0;
                        w_timeout_cnt_d = 8'd0;
                    end else begin
                        w_timeout_cnt_d = r_timeout_cnt + 8'd1;
                    end
                end
            end
            StLoadTime, StLoadAlarm: begin
                // Keys arriving here are dropped.
                w_state_d       = StIdle;
                w_key_buffer_d  = 16'h0000;
                w_digit_cnt_d   = 3'd0;
                w_timeout_cnt_d = 8'd0;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= StIdle;
            r_key_buffer    <= 16'h0000;
            r_digit_cnt     <= 3'd0;
            r_timeout_cnt   <= 8'd0;
            r_time_out      <= 16'h0000;
            r_load_new_time <= 1'b0;
            r_load_alarm    <= 1'b0;
            r_entry_error   <= 1'b0;
            r_show_keys     <= 1'b0;
        end else begin
            r_state         <= w_state_d;
            r_key_buffer    <= w_key_buffer_d;
            r_digit_cnt     <= w_digit_cnt_d;
            r_timeout_cnt   <= w_timeout_cnt_d;
            r_time_out      <= w_time_out_d;
            // Strobes are high exactly while the FSM sits in the matching load state.
            r_load_new_time <= (w_state_d == StLoadTime);
            r_load_alarm    <= (w_state_d == StLoadAlarm);
            r_entry_error   <= w_entry_error_d;
            r_show_keys     <= (w_state_d == StEntry);
        end
    end

    assign o_time_out      = r_time_out;
    assign o_load_new_time = r_load_new_time;
    assign o_load_alarm    = r_load_alarm;
    assign o_entry_error   = r_entry_error;
    assign o_show_keys     = r_show_keys;
    assign o_display_time  = (r_state == StEntry) ? r_key_buffer : i_current_time;

endmodule

// File: doc/al_clk_set_ctrl.md
Name: al_clk_set_ctrl

Overview:
Keypad time-entry controller for the alarm clock. It collects four BCD digits from a keypad decoder and validates them as HH:MM. On a set key it issues a one-cycle load strobe, either to the clock counter (load_new_time / time_in) or to the alarm register. It also selects what the display shows: the digits being entered, or the running time.

Parameters:
TIMEOUT_TICKS, 10, number of one_second ticks with no key press before an entry in progress is abandoned (range 1..255)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
key_valid  input  1  single-cycle strobe; key_code is valid this cycle
key_code  input  4  0x0-0x9 digit, 0xA set-time, 0xB set-alarm, 0xC cancel, 0xD-0xF ignored
one_second  input  1  single-cycle tick, once per second
current_time  input  16  BCD HH:MM from the clock counter
time_out  output  16  committed BCD value; drives counter time_in and alarm register data
load_new_time  output  1  one-cycle strobe to the clock counter
load_alarm  output  1  one-cycle strobe to the alarm register
display_time  output  16  BCD value to be displayed
show_keys  output  1  high while an entry is in progress
entry_error  output  1  one-cycle strobe on a rejected commit

Behaviour:
- Reset: reset is synchronous, active-high.
  - state=IDLE; key_buffer=16'h0000; digit_cnt=0; timeout_cnt=0.
  - time_out=16'h0000; load_new_time=0, load_alarm=0, entry_error=0, show_keys=0.
- All outputs are registered except display_time, which is combinational:
  - ENTRY: display_time = key_buffer.
  - Otherwise: display_time = current_time.
- show_keys = 1 exactly when state==ENTRY.
- States: IDLE, ENTRY, LOAD_TIME, LOAD_ALARM.
- IDLE:
  - Digit key -> ENTRY; key_buffer={12'h000,digit}; digit_cnt=1; timeout_cnt=0.
  - Set/cancel/ignored codes -> stay IDLE. No strobe, no error.
- ENTRY, digit key:
  - key_buffer={key_buffer[11:0],digit}.
  - digit_cnt increments and saturates at 4; the oldest digit is discarded.
  - timeout_cnt=0.
- ENTRY, cancel:
  - -> IDLE; key_buffer=0; digit_cnt=0. No error.
- ENTRY, set key (0xA/0xB): commit is valid iff ALL of the following hold:
  - digit_cnt==4
  - H1=key_buffer[15:12] <= 2
  - H0=key_buffer[11:8] <= 9, and H0 <= 3 when H1==2
  - M1=key_buffer[7:4] <= 5
  - M0=key_buffer[3:0] <= 9
- Valid commit:
  - time_out <= key_buffer.
  - -> LOAD_TIME (0xA) or LOAD_ALARM (0xB).
- Invalid commit:
  - entry_error=1 for one cycle; -> IDLE; key_buffer=0; digit_cnt=0.
  - time_out unchanged; no load strobe.
- LOAD_TIME: load_new_time=1 for exactly this one cycle; then -> IDLE with key_buffer cleared. LOAD_ALARM is the same, using load_alarm.
- Latency: a set key sampled at edge N gives time_out updated and the load strobe high in cycle N+1. time_out is held stable through the strobe and afterwards until the next valid commit.
- Keys arriving in LOAD_TIME or LOAD_ALARM are dropped.
- Timeout: in ENTRY, each one_second tick increments timeout_cnt. When it reaches TIMEOUT_TICKS:
  - -> IDLE; buffer cleared; no error; no strobe.
- key_valid and one_second in the same cycle in ENTRY: the key is processed and timeout_cnt=0 (the key wins). A timeout expiring in the same cycle as a key press does not fire.
- load_new_time and load_alarm are never high in the same cycle. At most one strobe fires per commit.
- Reset asserted mid-entry or during a LOAD state: the reset values above are forced on the next edge. A pending strobe is suppressed.

Test Plan:
- Reset, then idle for 100 cycles -> all strobes 0; time_out=16'h0000; show_keys=0; display_time follows current_time (e.g. 16'h0915).
- Keys 1,2,3,4 then 0xA -> show_keys=1 during entry; display_time goes 0001, 0012, 0123, 1234; one cycle after the set key, time_out=16'h1234 and load_new_time is high for exactly one cycle; then IDLE, show_keys=0.
- Keys 2,3,5,9 then 0xB -> time_out=16'h2359 and one load_alarm pulse; load_new_time stays 0. Keys 2,4,0,0 then 0xA -> entry_error is one pulse; time_out stays 16'h2359; no strobe.
- Keys 1,2 then 0xA -> entry_error pulse (only 2 digits). Keys 0,1,2,3,4,5 then 0xA -> buffer 16'h2345 and load_new_time pulse (overflow digits shifted out).
- TIMEOUT_TICKS=3, key 7, then 3 one_second ticks -> IDLE on the third tick, no error/strobe. Repeat with a key press coincident with the third tick -> stays in ENTRY, timeout_cnt restarts.
- Key 1, then reset asserted together with the 0xA key one cycle later -> no load strobe ever fires; time_out=16'h0000; state IDLE. Keys 0,9 then 0xC -> IDLE, buffer cleared, no error.
